// File: rtl/micro_sequencer_pkg.sv
// Shared constants and helpers for the picoRISC microprogram sequencer.
// The translation logic and the opcode/addressing-mode mappers import these too.
package micro_sequencer_pkg;

  localparam int UPC_W = 8;
  localparam int T_W   = 1 << UPC_W;

  localparam logic [UPC_W-1:0] MAX_UPC = 8'd55;

  localparam logic [UPC_W-1:0] TGT_FETCH = 8'd0;
  localparam logic [UPC_W-1:0] TGT_9     = 8'd9;
  localparam logic [UPC_W-1:0] TGT_17    = 8'd17;
  localparam logic [UPC_W-1:0] TGT_19    = 8'd19;
  localparam logic [UPC_W-1:0] TGT_41    = 8'd41;
  localparam logic [UPC_W-1:0] TGT_49    = 8'd49;

  localparam int SIG_FETCH = 15;
  localparam int SIG_9     = 14;
  localparam int SIG_17    = 13;
  localparam int SIG_19    = 12;
  localparam int SIG_41    = 11;
  localparam int SIG_49    = 10;

  typedef enum logic [1:0] {
    SEL_INC,
    SEL_OPR,
    SEL_ADR,
    SEL_TGT
  } nextSel_e;

  typedef struct packed {
    logic             valid;
    logic [UPC_W-1:0] addr;
  } target_t;

  // Highest set target bit wins; no bit set means there is no legal target.
  function automatic target_t encodeTarget(input logic [5:0] sigHi);
    target_t t;
    t.valid = 1'b1;
    if      (sigHi[SIG_FETCH-10]) t.addr = TGT_FETCH;
    else if (sigHi[SIG_9-10])     t.addr = TGT_9;
    else if (sigHi[SIG_17-10])    t.addr = TGT_17;
    else if (sigHi[SIG_19-10])    t.addr = TGT_19;
    else if (sigHi[SIG_41-10])    t.addr = TGT_41;
    else if (sigHi[SIG_49-10])    t.addr = TGT_49;
    else begin
      t.valid = 1'b0;
      t.addr  = TGT_FETCH;
    end
    return t;
  endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Bus between the sequencer and the translation logic, mappers and wait handshake.
interface micro_sequencer_if;
  import micro_sequencer_pkg::*;

  logic [T_W-1:0]   T;
  logic [UPC_W-1:0] upc;
  logic             bropr;
  logic             bradr;
  logic             bruncnd;
  logic             brcnd;
  logic [15:0]      signals;
  logic [UPC_W-1:0] mopr;
  logic [UPC_W-1:0] madr;
  logic             hold;
  logic             fault;
  logic [UPC_W-1:0] fault_upc;

  modport master (
    input  T, upc, fault, fault_upc,
    output bropr, bradr, bruncnd, brcnd, signals, mopr, madr, hold
  );

  modport slave (
    output T, upc, fault, fault_upc,
    input  bropr, bradr, bruncnd, brcnd, signals, mopr, madr, hold
  );

endinterface

// File: rtl/micro_sequencer_upc_decoder.sv
// Binary uPC to one-hot step vector; shared with the trace unit.
module upc_decoder #(
  parameter int W = 8
) (
  input  logic [W-1:0]        i_upc,
  output logic [(1<<W)-1:0]   o_t
);

  localparam logic [(1<<W)-1:0] ONE = {{((1<<W)-1){1'b0}}, 1'b1};

  assign o_t = ONE << i_upc;

endmodule

// File: rtl/micro_sequencer.sv
// picoRISC microprogram sequencer: uPC register, next-address selection,
// range check and sticky fault capture.
module micro_sequencer
  import micro_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  micro_sequencer_if.slave   bus
);

  logic [UPC_W-1:0] r_upc;
  logic             r_fault;
  logic [UPC_W-1:0] r_faultUpc;

  nextSel_e         w_sel;
  target_t          w_target;
  logic [UPC_W-1:0] w_cand;
  logic             w_candBad;
  logic [UPC_W-1:0] w_next;
  logic             w_faultNow;
  logic             w_unused;

  assign w_unused = &{1'b0, bus.signals[9:0]};
  assign w_target = encodeTarget(bus.signals[15:10]);

  always_comb begin
    w_sel = SEL_INC;
    if      (bus.bropr)               w_sel = SEL_OPR;
    else if (bus.bradr)               w_sel = SEL_ADR;
    else if (bus.bruncnd | bus.brcnd) w_sel = SEL_TGT;
  end

  // Increment wraps naturally at the top of the uPC range; the range check catches it.
  always_comb begin
    w_cand    = r_upc + 1'b1;
    w_candBad = 1'b0;
    unique case (w_sel)
      SEL_OPR: w_cand = bus.mopr;
      SEL_ADR: w_cand = bus.madr;
      SEL_TGT: begin
        w_cand    = w_target.addr;
        w_candBad = ~w_target.valid;
      end
      default: w_cand = r_upc + 1'b1;
    endcase
  end

  always_comb begin
    w_faultNow = w_candBad | (w_cand > MAX_UPC);
    w_next     = w_faultNow ? TGT_FETCH : w_cand;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_upc      <= '0;
      r_fault    <= 1'b0;
      r_faultUpc <= '0;
    end else if (!bus.hold) begin
      r_upc <= w_next;
      if (w_faultNow) begin
        r_fault <= 1'b1;
        if (!r_fault) r_faultUpc <= r_upc;
      end
    end
  end

  upc_decoder #(.W(UPC_W)) u_decoder (
    .i_upc (r_upc),
    .o_t   (bus.T)
  );

  assign bus.upc       = r_upc;
  assign bus.fault     = r_fault;
  assign bus.fault_upc = r_faultUpc;

endmodule
